// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arbState_t;

  localparam int          MAX_NUM_REQ      = 8;
  localparam logic [7:0]  DEFAULT_TAG_BASE = 8'hF0;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first request above pointer, wrapping,
// restricted to lockMask when any lock bit is set.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] reqVec,
  input  logic [ID_W-1:0]    pointer,
  input  logic [NUM_REQ-1:0] lockMask,
  output logic [ID_W-1:0]    winner,
  output logic               winnerValid
);

  logic [NUM_REQ-1:0] cand;

  always_comb begin
    winner      = '0;
    winnerValid = 1'b0;
    cand        = (|lockMask) ? (reqVec & lockMask) : reqVec;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!winnerValid && cand[j] && ((int'(pointer) + k) % NUM_REQ) == j) begin
          winnerValid = 1'b1;
          winner      = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UartTx between NUM_REQ byte producers, with per-requester lock.
// Optional source tag byte before each change of requester: define UART_TX_ARBITER_TAG_EN.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int         NUM_REQ  = 4,
  parameter int         ID_W     = 3,
  parameter logic [7:0] TAG_BASE = DEFAULT_TAG_BASE
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NUM_REQ-1:0]     ReqValid,
  input  logic [8*NUM_REQ-1:0]   ReqData,
  input  logic [NUM_REQ-1:0]     ReqLock,
  output logic [NUM_REQ-1:0]     ReqAck,
  output logic [NUM_REQ-1:0]     Grant,
  output logic [7:0]             TxDataOut,
  output logic                   TxEnableOut,
  input  logic                   TxReadyIn,
  output logic                   Busy
);

  // state     | meaning
  // IDLE      | no transfer; arbitrate when a request is pending and UART is ready
  // ISSUE     | TxEnableOut high until UART takes the byte
  // WAIT_BUSY | UART accepted but may still show ready for a cycle
  // WAIT_DONE | frame on the wire; wait for ready to return

  if ((2**ID_W) < NUM_REQ || NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ || TAG_BASE[3:0] != 4'h0) begin : gParamCheck
    $fatal(1, "uart_tx_arbiter: illegal parameter combination");
  end

  arbState_t           state;
  logic [ID_W-1:0]     pointer;
  logic [ID_W-1:0]     winner;
  logic                winnerValid;
  logic [NUM_REQ-1:0]  lockMask;
  logic [NUM_REQ-1:0]  winOneHot;
  logic [7:0]          winData;

  assign lockMask = ReqLock & Grant;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) uPick (
    .reqVec     (ReqValid),
    .pointer    (pointer),
    .lockMask   (lockMask),
    .winner     (winner),
    .winnerValid(winnerValid)
  );

  always_comb begin
    winOneHot = '0;
    winData   = 8'h00;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (winner == ID_W'(j)) begin
        winOneHot[j] = 1'b1;
        winData      = ReqData[8*j +: 8];
      end
    end
  end

`ifdef UART_TX_ARBITER_TAG_EN
  logic [ID_W-1:0] lastTag;
  logic            lastTagValid;
  logic [7:0]      pendData;
  logic            pendValid;
  logic            needTag;

  assign needTag = !lastTagValid || (lastTag != winner);
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      pointer   <= ID_W'(NUM_REQ-1);
      Grant     <= '0;
      ReqAck    <= '0;
      TxDataOut <= 8'h00;
`ifdef UART_TX_ARBITER_TAG_EN
      lastTag      <= '0;
      lastTagValid <= 1'b0;
      pendData     <= 8'h00;
      pendValid    <= 1'b0;
`endif
    end else begin
      ReqAck <= '0;
      unique case (state)
        IDLE: begin
          if (winnerValid && TxReadyIn) begin
            ReqAck  <= winOneHot;
            Grant   <= winOneHot;
            pointer <= winner;
            state   <= ISSUE;
`ifdef UART_TX_ARBITER_TAG_EN
            if (needTag) begin
              TxDataOut    <= TAG_BASE | 8'(winner);
              pendData     <= winData;
              pendValid    <= 1'b1;
              lastTag      <= winner;
              lastTagValid <= 1'b1;
            end else begin
              TxDataOut <= winData;
            end
`else
            TxDataOut <= winData;
`endif
          end else if (!(|lockMask)) begin
            Grant <= '0;
          end
        end
        ISSUE: begin
          if (TxReadyIn) state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!TxReadyIn) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (TxReadyIn) begin
`ifdef UART_TX_ARBITER_TAG_EN
            if (pendValid) begin
              TxDataOut <= pendData;
              pendValid <= 1'b0;
              state     <= ISSUE;
            end else begin
              state <= IDLE;
              if (!(|lockMask)) Grant <= '0;
            end
`else
            state <= IDLE;
            if (!(|lockMask)) Grant <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign TxEnableOut = (state == ISSUE);
  assign Busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UartTx stand-in; tag expectations follow UART_TX_ARBITER_TAG_EN.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 3;
  localparam int FRAME   = 8;

  logic                 Clk = 1'b0;
  logic                 Reset = 1'b1;
  logic [NUM_REQ-1:0]   ReqValid = '0;
  logic [8*NUM_REQ-1:0] ReqData = '0;
  logic [NUM_REQ-1:0]   ReqLock = '0;
  logic [NUM_REQ-1:0]   ReqAck;
  logic [NUM_REQ-1:0]   Grant;
  logic [7:0]           TxDataOut;
  logic                 TxEnableOut;
  logic                 TxReadyIn;
  logic                 Busy;

  int         checks = 0;
  int         errors = 0;
  int         uartCnt;
  logic       uartStart;
  logic       forceLow = 1'b0;
  int         lastTagExp = -1;
  logic [7:0] txLog[$];
  logic [7:0] expLog[$];

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TAG_BASE(8'hF0)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .ReqValid   (ReqValid),
    .ReqData    (ReqData),
    .ReqLock    (ReqLock),
    .ReqAck     (ReqAck),
    .Grant      (Grant),
    .TxDataOut  (TxDataOut),
    .TxEnableOut(TxEnableOut),
    .TxReadyIn  (TxReadyIn),
    .Busy       (Busy)
  );

  always #5 Clk = ~Clk;

  // UartTx stand-in: ready stays high one cycle after accepting, then low for FRAME cycles.
  assign TxReadyIn = (uartCnt == 0) && !forceLow;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      uartCnt   <= 0;
      uartStart <= 1'b0;
    end else if (uartStart) begin
      uartCnt   <= FRAME;
      uartStart <= 1'b0;
    end else if (uartCnt > 0) begin
      uartCnt <= uartCnt - 1;
    end else if (TxEnableOut && TxReadyIn) begin
      txLog.push_back(TxDataOut);
      uartStart <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic expByte(input int idx, input logic [7:0] d);
`ifdef UART_TX_ARBITER_TAG_EN
    if (lastTagExp != idx) expLog.push_back(8'hF0 | 8'(idx));
`endif
    lastTagExp = idx;
    expLog.push_back(d);
  endtask

  task automatic waitAck(input int idx, input string name);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      tick();
      if (ReqAck[idx]) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic waitIdle(input string name);
    logic idle;
    idle = 1'b0;
    for (int n = 0; n < 400 && !idle; n++) begin
      tick();
      if (!Busy) idle = 1'b1;
    end
    check(name, {31'd0, idle}, 32'd1);
  endtask

  task automatic waitLog(input int count, input string name);
    for (int n = 0; n < 2000 && txLog.size() < count; n++) tick();
    check(name, txLog.size() >= count ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic checkLog(input string name);
    check({name, "_count"}, txLog.size(), expLog.size());
    for (int i = 0; i < expLog.size(); i++) begin
      if (i < txLog.size()) check(name, {24'd0, txLog[i]}, {24'd0, expLog[i]});
    end
    txLog.delete();
    expLog.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("rst_ack",   {28'd0, ReqAck}, 32'd0);
    check("rst_grant", {28'd0, Grant},  32'd0);
    check("rst_data",  {24'd0, TxDataOut}, 32'd0);
    check("rst_txen",  {31'd0, TxEnableOut}, 32'd0);
    check("rst_busy",  {31'd0, Busy}, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    tick();

    // Single requester 2
    ReqData[23:16] = 8'hA5;
    ReqValid       = 4'b0100;
    expByte(2, 8'hA5);
    tick();
    check("t1_ack",   {28'd0, ReqAck}, 32'h4);
    check("t1_txen",  {31'd0, TxEnableOut}, 32'd1);
    check("t1_grant", {28'd0, Grant}, 32'h4);
    check("t1_busy",  {31'd0, Busy}, 32'd1);
    check("t1_data",  {24'd0, TxDataOut}, {24'd0, expLog[0]});
    ReqValid = 4'b0000;
    tick();
    check("t1_ack_pulse", {28'd0, ReqAck}, 32'd0);
    check("t1_txen_once", {31'd0, TxEnableOut}, 32'd0);
    repeat (4) tick();
    check("t1_grant_held", {28'd0, Grant}, 32'h4);
    waitIdle("t1_idle");
    check("t1_grant_rel", {28'd0, Grant}, 32'd0);
    checkLog("t1_wire");

    // Rotation with all four requesters valid from reset
    Reset = 1'b0;
    lastTagExp = -1;
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    ReqData  = {8'h43, 8'h32, 8'h21, 8'h10};
    ReqValid = 4'b1111;
    for (int i = 0; i < 5; i++) expByte(i % 4, 8'h10 + 8'(i % 4) * 8'h11);
    waitLog(expLog.size(), "t2_progress");
    ReqValid = 4'b0000;
    waitIdle("t2_idle");
    checkLog("t2_order");

    // Lock: requester 1 keeps grant for three bytes while requester 0 waits
    ReqData[15:8] = 8'h55;
    ReqLock       = 4'b0010;
    ReqValid      = 4'b0010;
    expByte(1, 8'h55);
    waitAck(1, "t3_ack55");
    ReqData[15:8] = 8'h66;
    ReqData[7:0]  = 8'h11;
    ReqValid      = 4'b0011;
    expByte(1, 8'h66);
    waitAck(1, "t3_ack66");
    check("t3_grant66", {28'd0, Grant}, 32'h2);
    ReqData[15:8] = 8'h77;
    expByte(1, 8'h77);
    waitAck(1, "t3_ack77");
    check("t3_grant77", {28'd0, Grant}, 32'h2);
    ReqValid = 4'b0001;
    waitIdle("t3_idle");
    repeat (3) tick();
    check("t3_hold_grant", {28'd0, Grant}, 32'h2);
    check("t3_blocked",    {28'd0, ReqAck}, 32'd0);
    ReqLock = 4'b0000;
    expByte(0, 8'h11);
    waitAck(0, "t3_ack11");
    check("t3_grant0", {28'd0, Grant}, 32'h1);
    ReqValid = 4'b0000;
    waitIdle("t3_idle2");
    checkLog("t3_wire");

    // TxReadyIn held low on entry to ISSUE
    ReqData[31:24] = 8'h3C;
    ReqValid       = 4'b1000;
    expByte(3, 8'h3C);
    tick();
    check("t4_ack", {28'd0, ReqAck}, 32'h8);
    ReqValid = 4'b0000;
    forceLow = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_txen_held", {31'd0, TxEnableOut}, 32'd1);
    end
    forceLow = 1'b0;
    tick();
    check("t4_txen_drop", {31'd0, TxEnableOut}, 32'd0);
    waitIdle("t4_idle");
    checkLog("t4_wire");

    // Reset mid-frame
    ReqData[7:0] = 8'h77;
    ReqValid     = 4'b0001;
    tick();
    ReqValid = 4'b0000;
    repeat (6) tick();
    check("t5_busy_before", {31'd0, Busy}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    check("t5_grant", {28'd0, Grant}, 32'd0);
    check("t5_busy",  {31'd0, Busy}, 32'd0);
    check("t5_txen",  {31'd0, TxEnableOut}, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    lastTagExp = -1;
    txLog.delete();
    expLog.delete();
    ReqData[15:8] = 8'h5A;
    ReqValid      = 4'b0010;
    expByte(1, 8'h5A);
    waitAck(1, "t5_ack");
    check("t5_grant_after", {28'd0, Grant}, 32'h2);
    ReqValid = 4'b0000;
    waitIdle("t5_idle");
    checkLog("t5_wire");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
